violation_reset_ctrl: RTL and testbench
=======================================

# violation_reset_ctrl

Reset sequencer directly downstream of the attestation-region violation detectors. It takes their level-sensitive reset requests, including the IRQ/DMA-during-protected-code detector. It drives one registered, minimum-width system reset into the MCU core, so every violation produces a clean reset of guaranteed length. It also keeps sticky cause bits and a saturating violation counter for post-reset firmware to read.

## Interface
- NUM_SRC, 4, number of detector request inputs; bit 0 is the IRQ/DMA detector
- MIN_PULSE, 16, minimum system_rst assertion length in clk cycles after a violation (≥1)
- CNT_W, 8, width of violation counter
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low block reset (power-on)
- viol_req  in  NUM_SRC  per-detector reset request, level, active-high, synchronous to clk
- cause_clr  in  1  one-cycle pulse from firmware: clear sticky cause
- system_rst  out  1  registered reset to MCU core, active-high
- cause  out  NUM_SRC  sticky OR of all request bits seen since last clear
- first_cause  out  NUM_SRC  snapshot of viol_req on the cycle the latest violation episode started
- viol_cnt  out  CNT_W  number of violation episodes, saturating
- state  out  2  current FSM state, for debug

## Operation
- States: BOOT=0, IDLE=1, STRETCH=2, WAIT_CLR=3.
- Values while reset_n low: state=BOOT, system_rst=1, cause=0, first_cause=0, viol_cnt=0, stretch counter=0.
- BOOT: system_rst=1. Detectors power up requesting reset, so requests are not counted and not logged here. Go to IDLE when viol_req==0.
- IDLE: system_rst=0. If |viol_req, go to STRETCH:
  - load counter with MIN_PULSE-1
  - first_cause<=viol_req
  - cause<=cause|viol_req
  - viol_cnt<=viol_cnt+1, saturating at 2^CNT_W-1
- STRETCH: system_rst=1. Counter decrements each cycle. At counter==0: go to IDLE if viol_req==0, else go to WAIT_CLR.
- WAIT_CLR: system_rst=1. Go to IDLE on the first cycle viol_req==0. No timeout: detectors release only once the core sits at its reset vector, and a held reset guarantees that.
- One episode counts once. Requests that rise in STRETCH or WAIT_CLR are OR-ed into cause every cycle. They do not change first_cause or viol_cnt and do not restart the counter.
- cause_clr is honoured only in IDLE with no request that cycle, and then sets cause<=0.
  - cause_clr together with a new violation in IDLE: violation wins, cause<=viol_req (old bits dropped).
  - cause_clr in any other state: ignored.
- viol_cnt and first_cause are never cleared except by reset_n.

## Timing
- All outputs are registered. system_rst asserts asynchronously when reset_n falls and deasserts synchronously.
- Latency: viol_req high at edge N, in IDLE → system_rst=1 after edge N (first visible cycle N+1).
- Pulse length when requests drop before the counter expires: exactly MIN_PULSE cycles.
- Pulse length when requests persist: MIN_PULSE cycles plus the cycles until the first edge where viol_req==0. system_rst=0 after that edge.
- Back-to-back: a request present on the first IDLE cycle starts a new episode immediately. system_rst can drop for as little as one cycle.
- Reset mid-operation: reset_n low in any state returns everything to reset values at once. The stretch is aborted, but system_rst stays 1 through the abort.
- Width rules:
  - stretch counter width is $clog2(MIN_PULSE+1)
  - viol_cnt increment uses saturation compare, never wraps

## Test plan
- Boot: release reset_n with viol_req=4'b0001 for 5 cycles, then 0 → system_rst=1 throughout, state BOOT→IDLE, system_rst=0 one cycle after req drops, viol_cnt=0, cause=0.
- Short violation: IDLE, viol_req=4'b0001 for 1 cycle → system_rst high for exactly 16 cycles starting next cycle, first_cause=4'b0001, cause=4'b0001, viol_cnt=1.
- Held request: viol_req=4'b0010 held 30 cycles → STRETCH 16 cycles then WAIT_CLR. system_rst deasserts the cycle after req drops, viol_cnt+1 only once.
- Merge within episode: bit0 at cycle 0, bit2 rises at cycle 5 → cause=4'b0101, first_cause=4'b0001, viol_cnt increments by 1.
- cause_clr: pulse in IDLE → cause=0. Pulse in STRETCH → cause unchanged. Pulse together with viol_req=4'b1000 in IDLE → cause=4'b1000.
- Saturation and reset abort: with CNT_W=2, 5 episodes → viol_cnt=3. Drop reset_n at STRETCH cycle 7 → all outputs at reset values, system_rst stays 1.

Source files
------------

// File: rtl/violation_reset_ctrl_if.sv
// Bundle between the violation detectors/firmware and the reset sequencer.
// The master side drives the requests and the clear pulse. The slave side is the sequencer.
interface violation_reset_ctrl_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 8
);
  logic [NUM_SRC-1:0] viol_req;
  logic               cause_clr;
  logic               system_rst;
  logic [NUM_SRC-1:0] cause;
  logic [NUM_SRC-1:0] first_cause;
  logic [CNT_W-1:0]   viol_cnt;
  logic [1:0]         state;

  modport master (
    output viol_req,
    output cause_clr,
    input  system_rst,
    input  cause,
    input  first_cause,
    input  viol_cnt,
    input  state
  );

  modport slave (
    input  viol_req,
    input  cause_clr,
    output system_rst,
    output cause,
    output first_cause,
    output viol_cnt,
    output state
  );
endinterface

// File: rtl/violation_reset_ctrl.sv
// Reset sequencer: turns level violation requests into a registered, minimum-width system reset.
// It also keeps sticky cause bits, a first-cause snapshot and a saturating episode counter.
module violation_reset_ctrl #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MIN_PULSE = 16,
  parameter int unsigned CNT_W     = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  violation_reset_ctrl_if.slave bus
);
  localparam int unsigned STRETCH_W = $clog2(MIN_PULSE + 1);
  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StIdle    = 2'd1,
    StStretch = 2'd2,
    StWaitClr = 2'd3
  } state_e;

  state_e             state_q;
  logic               system_rst_q;
  logic [NUM_SRC-1:0] cause_q;
  logic [NUM_SRC-1:0] first_cause_q;
  logic [CNT_W-1:0]   viol_cnt_q;
  logic [STRETCH_W-1:0] stretch_q;
  logic               req_any;

  assign req_any = |bus.viol_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StBoot;
      system_rst_q  <= 1'b1;
      cause_q       <= '0;
      first_cause_q <= '0;
      viol_cnt_q    <= '0;
      stretch_q     <= '0;
    end else begin
      case (state_q)
        // Detectors power up asserted; wait for them to release without logging anything.
        StBoot: begin
          if (!req_any) begin
            state_q      <= StIdle;
            system_rst_q <= 1'b0;
          end
        end
        StIdle: begin
          if (req_any) begin
            state_q       <= StStretch;
            system_rst_q  <= 1'b1;
            stretch_q     <= STRETCH_LOAD;
            first_cause_q <= bus.viol_req;
            cause_q       <= bus.cause_clr ? bus.viol_req : (cause_q | bus.viol_req);
            if (viol_cnt_q != CNT_MAX) begin
              viol_cnt_q <= viol_cnt_q + 1'b1;
            end
          end else if (bus.cause_clr) begin
            cause_q <= '0;
          end
        end
        StStretch: begin
          cause_q <= cause_q | bus.viol_req;
          if (stretch_q == '0) begin
            if (req_any) begin
              state_q <= StWaitClr;
            end else begin
              state_q      <= StIdle;
              system_rst_q <= 1'b0;
            end
          end else begin
            stretch_q <= stretch_q - 1'b1;
          end
        end
        StWaitClr: begin
          cause_q <= cause_q | bus.viol_req;
          if (!req_any) begin
            state_q      <= StIdle;
            system_rst_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StBoot;
          system_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.system_rst  = system_rst_q;
  assign bus.cause       = cause_q;
  assign bus.first_cause = first_cause_q;
  assign bus.viol_cnt    = viol_cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_violation_reset_ctrl.sv
// Bench for violation_reset_ctrl: two instances (8-bit and 2-bit counters) share one stimulus.
// An episode-level model is compared against both every cycle.
module tb_violation_reset_ctrl;
  localparam int unsigned MIN_PULSE = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] req = 4'b0;
  logic       clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  violation_reset_ctrl_if #(.NUM_SRC(4), .CNT_W(8)) bus_a ();
  violation_reset_ctrl_if #(.NUM_SRC(4), .CNT_W(2)) bus_b ();

  assign bus_a.viol_req  = req;
  assign bus_a.cause_clr = clr;
  assign bus_b.viol_req  = req;
  assign bus_b.cause_clr = clr;

  violation_reset_ctrl #(.NUM_SRC(4), .MIN_PULSE(MIN_PULSE), .CNT_W(8)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  violation_reset_ctrl #(.NUM_SRC(4), .MIN_PULSE(MIN_PULSE), .CNT_W(2)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Episode model: boot flag, active-episode flag and the episode's age in cycles.
  bit         m_boot;
  bit         m_active;
  int         m_age;
  int         m_eps;
  logic [3:0] m_cause;
  logic [3:0] m_first;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_boot   <= 1'b1;
      m_active <= 1'b0;
      m_age    <= 0;
      m_eps    <= 0;
      m_cause  <= '0;
      m_first  <= '0;
    end else if (m_boot) begin
      if (req == 4'b0) m_boot <= 1'b0;
    end else if (!m_active) begin
      if (req != 4'b0) begin
        m_active <= 1'b1;
        m_age    <= 0;
        m_first  <= req;
        m_cause  <= clr ? req : (m_cause | req);
        m_eps    <= m_eps + 1;
      end else if (clr) begin
        m_cause <= '0;
      end
    end else begin
      m_cause <= m_cause | req;
      m_age   <= m_age + 1;
      if (m_age + 1 >= MIN_PULSE && req == 4'b0) m_active <= 1'b0;
    end
  end

  logic [1:0] exp_state;
  logic       exp_rst;
  logic [7:0] exp_cnt_a;
  logic [1:0] exp_cnt_b;

  always_comb begin
    exp_rst   = m_boot || m_active;
    exp_state = m_boot ? 2'd0 : (!m_active ? 2'd1 : ((m_age < MIN_PULSE) ? 2'd2 : 2'd3));
    exp_cnt_a = (m_eps > 255) ? 8'd255 : 8'(m_eps);
    exp_cnt_b = (m_eps > 3) ? 2'd3 : 2'(m_eps);
  end

  always @(negedge clk) begin
    chk("rst_a", bus_a.system_rst, exp_rst);
    chk("state_a", bus_a.state, exp_state);
    chk("cause_a", bus_a.cause, m_cause);
    chk("first_a", bus_a.first_cause, m_first);
    chk("cnt_a", bus_a.viol_cnt, exp_cnt_a);
    chk("rst_b", bus_b.system_rst, exp_rst);
    chk("state_b", bus_b.state, exp_state);
    chk("cause_b", bus_b.cause, m_cause);
    chk("cnt_b", bus_b.viol_cnt, exp_cnt_b);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (bus_a.state != 2'd1 && k < 200) begin
      step(1);
      k++;
    end
    chk(nm, 32'(k < 200), 32'd1);
  endtask

  task automatic count_rst(output int n);
    n = 0;
    @(negedge clk);
    while (bus_a.system_rst && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int len;

  initial begin
    req = 4'b0001;
    #1 reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    chk("boot_state", bus_a.state, 2'd0);
    chk("boot_rst", bus_a.system_rst, 1'b1);
    step(5);
    chk("boot_hold_rst", bus_a.system_rst, 1'b1);
    req = 4'b0;
    step(1);
    chk("boot_exit_state", bus_a.state, 2'd1);
    chk("boot_exit_rst", bus_a.system_rst, 1'b0);
    chk("boot_cnt", bus_a.viol_cnt, 8'd0);
    chk("boot_cause", bus_a.cause, 4'b0);
    step(2);

    // Single-cycle request: pulse must be exactly the minimum width.
    req = 4'b0001;
    step(1);
    req = 4'b0;
    count_rst(len);
    chk("short_len", len, 16);
    step(1);
    chk("short_first", bus_a.first_cause, 4'b0001);
    chk("short_cause", bus_a.cause, 4'b0001);
    chk("short_cnt", bus_a.viol_cnt, 8'd1);

    // Request held across the stretch window for 30 edges.
    req = 4'b0010;
    step(30);
    chk("held_state", bus_a.state, 2'd3);
    chk("held_rst", bus_a.system_rst, 1'b1);
    req = 4'b0;
    step(1);
    chk("held_release_rst", bus_a.system_rst, 1'b0);
    chk("held_cnt", bus_a.viol_cnt, 8'd2);
    chk("held_first", bus_a.first_cause, 4'b0010);
    chk("held_cause", bus_a.cause, 4'b0011);

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_idle", bus_a.cause, 4'b0);

    // Second source joins mid-episode; clear during stretch is ignored.
    req = 4'b0001;
    step(5);
    req = 4'b0101;
    step(3);
    req = 4'b0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_stretch", bus_a.cause, 4'b0101);
    wait_idle("merge_idle");
    chk("merge_cause", bus_a.cause, 4'b0101);
    chk("merge_first", bus_a.first_cause, 4'b0001);
    chk("merge_cnt", bus_a.viol_cnt, 8'd3);

    req = 4'b1000;
    clr = 1'b1;
    step(1);
    req = 4'b0;
    clr = 1'b0;
    chk("clr_viol_cause", bus_a.cause, 4'b1000);
    chk("clr_viol_cnt", bus_a.viol_cnt, 8'd4);
    wait_idle("clr_viol_idle");

    // Back-to-back: new request on the very first idle cycle.
    req = 4'b0001;
    step(1);
    req = 4'b0;
    step(16);
    chk("b2b_gap_rst", bus_a.system_rst, 1'b0);
    req = 4'b0100;
    step(1);
    req = 4'b0;
    chk("b2b_rst", bus_a.system_rst, 1'b1);
    chk("b2b_state", bus_a.state, 2'd2);
    chk("b2b_cnt_a", bus_a.viol_cnt, 8'd6);
    chk("sat_cnt_b", bus_b.viol_cnt, 2'd3);
    wait_idle("b2b_idle");

    // Abort a stretch with reset_n in its 7th cycle.
    req = 4'b0001;
    step(1);
    req = 4'b0;
    step(7);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_rst", bus_a.system_rst, 1'b1);
    chk("abort_state", bus_a.state, 2'd0);
    chk("abort_cause", bus_a.cause, 4'b0);
    chk("abort_first", bus_a.first_cause, 4'b0);
    chk("abort_cnt_a", bus_a.viol_cnt, 8'd0);
    chk("abort_cnt_b", bus_b.viol_cnt, 2'd0);
    step(1);
    reset_n = 1'b1;
    step(1);
    chk("post_abort_state", bus_a.state, 2'd1);
    chk("post_abort_rst", bus_a.system_rst, 1'b0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
